// File: rtl/warp_barrier_ctrl.sv
// Purpose : per-core barrier scheduler; holds arriving warps and releases all participants together.
// Latency : release pulse 1 cycle after the final arrival is accepted; stall bits follow the same edge.
// Backpressure: none, req_ready is always 1; bad requests (duplicate warp, out-of-range id) set err and are dropped.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid/req_ready          decoded barrier request from the execute stage
//   req_wid, req_bar_id          requesting warp and target barrier
//   req_size_m1                  participating warps minus one
//   stall_mask                   warps held at any barrier (to warp scheduler)
//   release_valid/_bar_id/_mask  one-cycle release pulse; id/mask are 0 when idle
//   busy_mask                    barriers with at least one waiter
//   err                          sticky protocol error
//   timeout                      one-cycle pulse on a watchdog forced release
//
// Optional feature macro: BARRIER_TIMEOUT_EN (per-barrier watchdog, TIMEOUT_CYCLES).
// Without it, timeout is tied to 0 and no watchdog logic exists.

module warp_barrier_ctrl #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
`ifdef BARRIER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NW_BITS-1:0]      req_wid,
    input  logic [NB_BITS-1:0]      req_bar_id,
    input  logic [NW_BITS-1:0]      req_size_m1,
    output logic [NUM_WARPS-1:0]    stall_mask,
    output logic                    release_valid,
    output logic [NB_BITS-1:0]      release_bar_id,
    output logic [NUM_WARPS-1:0]    release_mask,
    output logic [NUM_BARRIERS-1:0] busy_mask,
    output logic                    err,
    output logic                    timeout
);

    // Per-barrier state. cnt counts arrivals so far; the final arrival is the one
    // that finds cnt == size.
    logic [NUM_BARRIERS-1:0] active_q, active_d;
    logic [NW_BITS-1:0]      cnt_q   [NUM_BARRIERS];
    logic [NW_BITS-1:0]      cnt_d   [NUM_BARRIERS];
    logic [NW_BITS-1:0]      size_q  [NUM_BARRIERS];
    logic [NW_BITS-1:0]      size_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    wmask_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    wmask_d [NUM_BARRIERS];

    logic                    rel_vld_q, rel_vld_d;
    logic [NB_BITS-1:0]      rel_bar_q, rel_bar_d;
    logic [NUM_WARPS-1:0]    rel_mask_q, rel_mask_d;
    logic                    err_q, err_d;

    logic [NUM_WARPS-1:0]    wid_bit;
    logic [NUM_WARPS-1:0]    held_mask;
    logic                    dup;
    logic                    bar_ok;
    logic                    wid_ok;

    assign req_ready = 1'b1;

    // Ids beyond the configured range only exist for non power-of-two sizes.
    if ((1 << NB_BITS) == NUM_BARRIERS) begin : g_bar_full
        assign bar_ok = 1'b1;
    end else begin : g_bar_part
        assign bar_ok = (int'(req_bar_id) < NUM_BARRIERS);
    end

    if ((1 << NW_BITS) == NUM_WARPS) begin : g_wid_full
        assign wid_ok = 1'b1;
    end else begin : g_wid_part
        assign wid_ok = (int'(req_wid) < NUM_WARPS);
    end

    assign wid_bit = NUM_WARPS'(1) << req_wid;

    always_comb begin
        held_mask = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            held_mask = held_mask | wmask_q[b];
        end
    end

    // A warp already held anywhere cannot legally arrive again.
    assign dup = |(held_mask & wid_bit);

`ifdef BARRIER_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_BITS-1:0]      wd_q [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] wd_expired;
    logic                    tmo_taken;
    logic                    tmo_q;

    always_comb begin
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            wd_expired[b] = (wd_q[b] == WD_BITS'(TIMEOUT_CYCLES));
        end
    end

    // Watchdog restarts from zero whenever the barrier is idle and saturates
    // once expired, so a deferred forced release is never lost.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (!reset_n || !active_q[b]) begin
                wd_q[b] <= '0;
            end else if (!wd_expired[b]) begin
                wd_q[b] <= wd_q[b] + WD_BITS'(1);
            end
        end
    end
`endif

    always_comb begin
        active_d   = active_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        wmask_d    = wmask_q;
        rel_vld_d  = 1'b0;
        rel_bar_d  = '0;
        rel_mask_d = '0;
        err_d      = err_q;
`ifdef BARRIER_TIMEOUT_EN
        tmo_taken  = 1'b0;
`endif

        if (req_valid) begin
            if (dup || !bar_ok || !wid_ok) begin
                err_d = 1'b1;
            end else if (!active_q[req_bar_id]) begin
                if (req_size_m1 == '0) begin
                    // Single-participant barrier: released at once, never stalled.
                    rel_vld_d  = 1'b1;
                    rel_bar_d  = req_bar_id;
                    rel_mask_d = wid_bit;
                end else begin
                    active_d[req_bar_id] = 1'b1;
                    cnt_d[req_bar_id]    = NW_BITS'(1);
                    size_d[req_bar_id]   = req_size_m1;
                    wmask_d[req_bar_id]  = wid_bit;
                end
            end else begin
                // The size latched by the first arriver always wins.
                if (req_size_m1 != size_q[req_bar_id]) begin
                    err_d = 1'b1;
                end
                if (cnt_q[req_bar_id] == size_q[req_bar_id]) begin
                    rel_vld_d            = 1'b1;
                    rel_bar_d            = req_bar_id;
                    rel_mask_d           = wmask_q[req_bar_id] | wid_bit;
                    active_d[req_bar_id] = 1'b0;
                    cnt_d[req_bar_id]    = '0;
                    wmask_d[req_bar_id]  = '0;
                end else begin
                    cnt_d[req_bar_id]   = cnt_q[req_bar_id] + NW_BITS'(1);
                    wmask_d[req_bar_id] = wmask_q[req_bar_id] | wid_bit;
                end
            end
        end

`ifdef BARRIER_TIMEOUT_EN
        // Forced release only in a cycle without a normal release, lowest id
        // first, and never on a barrier the current request is touching.
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (!rel_vld_d && !tmo_taken && active_q[b] && wd_expired[b]
                && !(req_valid && int'(req_bar_id) == b)) begin
                rel_vld_d  = 1'b1;
                rel_bar_d  = NB_BITS'(b);
                rel_mask_d = wmask_q[b];
                active_d[b] = 1'b0;
                cnt_d[b]    = '0;
                wmask_d[b]  = '0;
                tmo_taken   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q   <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                cnt_q[b]   <= '0;
                size_q[b]  <= '0;
                wmask_q[b] <= '0;
            end
            rel_vld_q  <= 1'b0;
            rel_bar_q  <= '0;
            rel_mask_q <= '0;
            err_q      <= 1'b0;
        end else begin
            active_q   <= active_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            wmask_q    <= wmask_d;
            rel_vld_q  <= rel_vld_d;
            rel_bar_q  <= rel_bar_d;
            rel_mask_q <= rel_mask_d;
            err_q      <= err_d;
        end
    end

`ifdef BARRIER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_taken;
        end
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    // Wait masks are registers, so the stall bits rise the cycle after the
    // accept and drop in the same cycle as the release pulse.
    assign stall_mask     = held_mask;
    assign busy_mask      = active_q;
    assign release_valid  = rel_vld_q;
    assign release_bar_id = rel_bar_q;
    assign release_mask   = rel_mask_q;
    assign err            = err_q;

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Purpose : self-checking bench for warp_barrier_ctrl (default build, 4 warps, 4 barriers).
// Latency : outputs compared 1 time unit after every rising edge against a queue-based model.
// Backpressure: none expected; req_ready is checked to stay 1.

module tb_warp_barrier_ctrl;

    localparam int NW = 4;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_wid = '0;
    logic [1:0]    req_bar_id = '0;
    logic [1:0]    req_size_m1 = '0;
    logic [NW-1:0] stall_mask;
    logic          release_valid;
    logic [1:0]    release_bar_id;
    logic [NW-1:0] release_mask;
    logic [NB-1:0] busy_mask;
    logic          err;
    logic          timeout;

    warp_barrier_ctrl #(
        .NUM_WARPS    (NW),
        .NUM_BARRIERS (NB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wid        (req_wid),
        .req_bar_id     (req_bar_id),
        .req_size_m1    (req_size_m1),
        .stall_mask     (stall_mask),
        .release_valid  (release_valid),
        .release_bar_id (release_bar_id),
        .release_mask   (release_mask),
        .busy_mask      (busy_mask),
        .err            (err),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: each barrier is a list of waiting warp ids plus the
    // size_m1 announced by its first arriver.
    int wq [NB][$];
    int lat [NB];
    bit m_err;
    bit m_rel;
    int m_rel_bar;
    int m_rel_mask;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int stall_exp();
        int m = 0;
        for (int b = 0; b < NB; b++) begin
            foreach (wq[b][i]) m |= (1 << wq[b][i]);
        end
        return m;
    endfunction

    function automatic int busy_exp();
        int m = 0;
        for (int b = 0; b < NB; b++) begin
            if (wq[b].size() != 0) m |= (1 << b);
        end
        return m;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            wq[b].delete();
            lat[b] = 0;
        end
        m_err      = 1'b0;
        m_rel      = 1'b0;
        m_rel_bar  = 0;
        m_rel_mask = 0;
    endtask

    task automatic model_req(input bit v, input int wid, input int bar, input int sz);
        int m;
        m_rel      = 1'b0;
        m_rel_bar  = 0;
        m_rel_mask = 0;
        if (!v) return;
        if ((stall_exp() >> wid) & 1) begin
            m_err = 1'b1;
            return;
        end
        if (wq[bar].size() == 0) begin
            if (sz == 0) begin
                m_rel      = 1'b1;
                m_rel_bar  = bar;
                m_rel_mask = 1 << wid;
            end else begin
                wq[bar].push_back(wid);
                lat[bar] = sz;
            end
        end else begin
            if (sz != lat[bar]) m_err = 1'b1;
            // Arrivals so far == size_m1 means this one completes the set.
            if (wq[bar].size() == lat[bar]) begin
                m = 1 << wid;
                foreach (wq[bar][i]) m |= (1 << wq[bar][i]);
                m_rel      = 1'b1;
                m_rel_bar  = bar;
                m_rel_mask = m;
                wq[bar].delete();
            end else begin
                wq[bar].push_back(wid);
            end
        end
    endtask

    task automatic check_all();
        chk_eq("release_valid",  release_valid,  m_rel);
        chk_eq("release_bar_id", release_bar_id, m_rel_bar);
        chk_eq("release_mask",   release_mask,   m_rel_mask);
        chk_eq("stall_mask",     stall_mask,     stall_exp());
        chk_eq("busy_mask",      busy_mask,      busy_exp());
        chk_eq("err",            err,            m_err);
        chk_eq("timeout",        timeout,        0);
        chk_eq("req_ready",      req_ready,      1);
    endtask

    task automatic cycle(input bit v, input int wid, input int bar, input int sz);
        req_valid   = v;
        req_wid     = 2'(wid);
        req_bar_id  = 2'(bar);
        req_size_m1 = 2'(sz);
        model_req(v, wid, bar, sz);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset with a live request on the bus: nothing may be captured.
    task automatic do_reset(input int n);
        reset_n     = 1'b0;
        req_valid   = 1'b1;
        req_wid     = 2'($urandom_range(0, 3));
        req_bar_id  = 2'($urandom_range(0, 3));
        req_size_m1 = 2'($urandom_range(0, 3));
        repeat (n) @(posedge clk);
        #1;
        model_clear();
        check_all();
        reset_n   = 1'b1;
        req_valid = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;

        // Reset held 2 cycles with req_valid=1.
        do_reset(2);
        chk_eq("rst_ready", req_ready, 1);
        chk_eq("rst_stall", stall_mask, 0);

        // Four warps on bar 1, size_m1=3.
        cycle(1, 0, 1, 3);
        chk_eq("b4_stall_1", stall_mask, 4'b0001);
        cycle(1, 1, 1, 3);
        chk_eq("b4_stall_2", stall_mask, 4'b0011);
        cycle(1, 2, 1, 3);
        chk_eq("b4_stall_3", stall_mask, 4'b0111);
        chk_eq("b4_busy",    busy_mask,  4'b0010);
        cycle(1, 3, 1, 3);
        chk_eq("b4_rel_vld",  release_valid,  1);
        chk_eq("b4_rel_bar",  release_bar_id, 1);
        chk_eq("b4_rel_mask", release_mask,   4'b1111);
        chk_eq("b4_stall_0",  stall_mask,     4'b0000);
        chk_eq("b4_busy_0",   busy_mask,      4'b0000);
        cycle(0, 0, 0, 0);
        chk_eq("b4_pulse_end", release_valid, 0);
        chk_eq("b4_mask_idle", release_mask,  0);

        // size_m1=0: immediate release, never stalled.
        cycle(1, 2, 0, 0);
        chk_eq("s0_rel_vld",  release_valid, 1);
        chk_eq("s0_rel_mask", release_mask,  4'b0100);
        chk_eq("s0_stall",    stall_mask,    4'b0000);

        // Interleaved bar0/bar1 pairs.
        cycle(1, 0, 0, 1);
        cycle(1, 1, 1, 1);
        cycle(1, 2, 0, 1);
        chk_eq("il_rel0_bar",  release_bar_id, 0);
        chk_eq("il_rel0_mask", release_mask,   4'b0101);
        cycle(1, 3, 1, 1);
        chk_eq("il_rel1_bar",  release_bar_id, 1);
        chk_eq("il_rel1_mask", release_mask,   4'b1010);
        chk_eq("il_rel1_vld",  release_valid,  1);

        // Duplicate arrival: err, arrival count unchanged.
        cycle(1, 0, 2, 1);
        cycle(1, 0, 2, 1);
        chk_eq("dup_err",   err,        1);
        chk_eq("dup_stall", stall_mask, 4'b0001);
        cycle(1, 1, 2, 1);
        chk_eq("dup_rel_mask", release_mask, 4'b0011);
        chk_eq("dup_err_sticky", err, 1);

        // Size mismatch: err, latched size 2 still governs completion.
        do_reset(1);
        chk_eq("mm_err_clr", err, 0);
        cycle(1, 0, 2, 2);
        cycle(1, 1, 2, 3);
        chk_eq("mm_err",   err,           1);
        chk_eq("mm_norel", release_valid, 0);
        cycle(1, 2, 2, 3);
        chk_eq("mm_rel_vld",  release_valid, 1);
        chk_eq("mm_rel_mask", release_mask,  4'b0111);

        // Random legal traffic: only free warps arrive, sizes agree.
        do_reset(1);
        for (int n = 0; n < 3000; n++) begin
            int free;
            int w;
            int b;
            int s;
            bit v;
            free = 'hF & ~stall_exp();
            if ($urandom_range(0, 99) < 2 || free == 0) begin
                do_reset($urandom_range(1, 2));
                continue;
            end
            v = ($urandom_range(0, 9) < 7);
            w = $urandom_range(0, 3);
            while (((free >> w) & 1) == 0) w = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            s = (wq[b].size() != 0) ? lat[b] : $urandom_range(0, 3);
            cycle(v, w, b, s);
        end

        // Random unconstrained traffic including duplicates and mismatches.
        for (int n = 0; n < 2000; n++) begin
            if (n % 150 == 0) do_reset(1);
            cycle($urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
